// File: rtl/message_scroller.sv
// message_scroller
// ----------------
// Scrolls the word SUCCESS or ERROR right-to-left across a 4-digit,
// time-multiplexed seven-segment display. Every cycle it presents one letter
// code for the shared decoder together with the matching active-low digit
// select.
//
// Handshake: Start is a request that is accepted only on an edge where the
// FSM is IDLE. Busy is the inverse of "ready": while Busy=1 every Start is
// dropped. Pass is captured only on the accepting edge. Done is a one-cycle
// completion pulse and needs no acknowledge.
//
// Ports
//   Clk          in   system clock, rising edge
//   nReset       in   synchronous, active-low reset
//   Start        in   scroll request
//   Pass         in   message select on accept: 1 = SUCCESS, 0 = ERROR
//   Loop         in   sampled at the end of each pass: 1 = scroll again
//   Code[2:0]    out  letter code E=0 R=1 O=2 S=3 U=4 C=5 blank=6
//   DigitSel[3:0]out  active-low one-hot digit enable, bit 0 = rightmost
//   Busy         out  high while a scroll is in progress
//   Done         out  one-cycle pulse when a scroll finishes
//   o_dbg_state  out  current FSM state (IDLE=0, SCROLL=1, DONE=2)
module message_scroller #(
  parameter int TICK_DIV = 25_000_000,
  parameter int MUX_DIV  = 50_000
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic       Pass,
  input  logic       Loop,
  output logic [2:0] Code,
  output logic [3:0] DigitSel,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] o_dbg_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [2:0] C_BLANK = 3'd6;

  logic [1:0]    r_state;
  logic          r_msg;      // 1 = SUCCESS, 0 = ERROR
  logic [3:0]    r_p;        // window position
  logic [TW-1:0] r_tick;     // scroll step counter
  logic [MW-1:0] r_mux;      // refresh slot counter
  logic [1:0]    r_d;        // digit currently refreshed
  logic [2:0]    r_code;
  logic [3:0]    r_sel;
  logic          r_busy;
  logic          r_done;

  logic [1:0] w_next_state;
  logic       w_tick_tc;
  logic       w_mux_tc;
  logic [3:0] w_last_p;
  logic [4:0] w_end;
  logic [4:0] w_idx;
  logic [4:0] w_off;
  logic [2:0] w_letter;

  assign w_tick_tc = (r_tick == TICK_LAST);
  assign w_mux_tc  = (r_mux == MUX_LAST);

  // Last window position is L+4: 11 for SUCCESS (L=7), 9 for ERROR (L=5).
  assign w_last_p = r_msg ? 4'd11 : 4'd9;
  // First trailing-blank index in the padded string (also L+4).
  assign w_end    = r_msg ? 5'd11 : 5'd9;

  // Padded string index shown on digit d: p+3-d. Never negative since d<=3.
  assign w_idx = {1'b0, r_p} + 5'd3 - {3'b000, r_d};
  assign w_off = w_idx - 5'd4;

  // Padded string lookup: 4 leading blanks, message, trailing blanks.
  always_comb begin
    w_letter = C_BLANK;
    if (w_idx >= 5'd4 && w_idx < w_end) begin
      if (r_msg) begin
        case (w_off)
          5'd0:    w_letter = 3'd3;  // S
          5'd1:    w_letter = 3'd4;  // U
          5'd2:    w_letter = 3'd5;  // C
          5'd3:    w_letter = 3'd5;  // C
          5'd4:    w_letter = 3'd0;  // E
          5'd5:    w_letter = 3'd3;  // S
          5'd6:    w_letter = 3'd3;  // S
          default: w_letter = C_BLANK;
        endcase
      end else begin
        case (w_off)
          5'd0:    w_letter = 3'd0;  // E
          5'd1:    w_letter = 3'd1;  // R
          5'd2:    w_letter = 3'd1;  // R
          5'd3:    w_letter = 3'd2;  // O
          5'd4:    w_letter = 3'd1;  // R
          default: w_letter = C_BLANK;
        endcase
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_next_state = S_SCROLL;
      S_SCROLL: if (w_tick_tc && (r_p == w_last_p) && !Loop) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_msg   <= 1'b0;
      r_p     <= 4'd0;
      r_tick  <= '0;
      r_mux   <= '0;
      r_d     <= 2'd0;
      r_code  <= C_BLANK;
      r_sel   <= 4'b1111;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Busy follows the next state so it rises on the accepting edge and
      // falls on the edge that leaves DONE, together with Done.
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (r_state == S_DONE);

      // Code and DigitSel come from the same registered view of p/d, so the
      // pair always changes together.
      if (r_state == S_SCROLL) begin
        r_code <= w_letter;
        r_sel  <= ~(4'b0001 << r_d);
      end else begin
        r_code <= C_BLANK;
        r_sel  <= 4'b1111;
      end

      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_msg  <= Pass;
            r_p    <= 4'd0;
            r_tick <= '0;
            r_mux  <= '0;
            r_d    <= 2'd0;
          end
        end
        S_SCROLL: begin
          if (w_tick_tc) begin
            r_tick <= '0;
            if (r_p != w_last_p) begin
              r_p <= r_p + 4'd1;
            end else if (Loop) begin
              r_p <= 4'd0;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end

          // Refresh runs independently of scroll steps and across loop wraps.
          if (w_mux_tc) begin
            r_mux <= '0;
            r_d   <= r_d + 2'd1;
          end else begin
            r_mux <= r_mux + MW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Code        = r_code;
  assign DigitSel    = r_sel;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_message_scroller.sv
// tb_message_scroller
// -------------------
// Drives message_scroller with directed scenarios followed by random traffic
// and compares every output on every cycle against a model that derives the
// display from elapsed-time arithmetic over the padded message string.
module tb_message_scroller;

  localparam int TICK = 8;
  localparam int MUX  = 2;

  localparam int M_IDLE   = 0;
  localparam int M_SCROLL = 1;
  localparam int M_DONE   = 2;

  logic       Clk;
  logic       nReset;
  logic       Start;
  logic       Pass;
  logic       Loop;
  logic [2:0] Code;
  logic [3:0] DigitSel;
  logic       Busy;
  logic       Done;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  int succ_rom[7] = '{3, 4, 5, 5, 0, 3, 3};
  int err_rom[5]  = '{0, 1, 1, 2, 1};

  int cap_a[4];
  int cap_b[4];

  message_scroller #(.TICK_DIV(TICK), .MUX_DIV(MUX)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .Start       (Start),
    .Pass        (Pass),
    .Loop        (Loop),
    .Code        (Code),
    .DigitSel    (DigitSel),
    .Busy        (Busy),
    .Done        (Done),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Character i of the padded string: 4 blanks, message, 4 blanks.
  function automatic int letter(input bit msg, input int i);
    int len;
    len = msg ? 7 : 5;
    if (i < 4 || i >= len + 4) return 6;
    return msg ? succ_rom[i - 4] : err_rom[i - 4];
  endfunction

  // ---------------- reference model ----------------
  int         m_state = M_IDLE;
  bit         m_msg   = 1'b0;
  int         m_el    = 0;   // edges since the current pass began
  int         m_tot   = 0;   // edges since Start was accepted
  logic [2:0] e_code  = 3'd6;
  logic [3:0] e_sel   = 4'b1111;
  logic       e_busy  = 1'b0;
  logic       e_done  = 1'b0;

  always @(posedge Clk) begin : model
    int p;
    int dd;
    if (!nReset) begin
      m_state = M_IDLE;
      e_code  = 3'd6;
      e_sel   = 4'b1111;
      e_busy  = 1'b0;
      e_done  = 1'b0;
    end else begin
      // Outputs reflect the window as it stood before this edge.
      e_done = (m_state == M_DONE);
      if (m_state == M_SCROLL) begin
        p      = m_el / TICK;
        dd     = (m_tot / MUX) % 4;
        e_code = 3'(letter(m_msg, p + 3 - dd));
        e_sel  = ~(4'b0001 << dd);
      end else begin
        e_code = 3'd6;
        e_sel  = 4'b1111;
      end
      case (m_state)
        M_IDLE: begin
          if (Start) begin
            m_msg   = Pass;
            m_el    = 0;
            m_tot   = 0;
            m_state = M_SCROLL;
          end
        end
        M_SCROLL: begin
          m_el++;
          m_tot++;
          // A pass is (L+5) frames of TICK clocks each.
          if (m_el == ((m_msg ? 7 : 5) + 5) * TICK) begin
            if (Loop) m_el = 0;
            else      m_state = M_DONE;
          end
        end
        default: m_state = M_IDLE;
      endcase
      e_busy = (m_state != M_IDLE);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cmp_code", Code, e_code);
      chk("cmp_sel", DigitSel, e_sel);
      chk("cmp_busy", Busy, e_busy);
      chk("cmp_done", Done, e_done);
    end
  end

  initial begin
    @(posedge Clk);
    #1 cmp_en = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic pin_frame(input string name, input bit msg, input int p,
                           input int e3, input int e2, input int e1, input int e0);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) chk(name, letter(msg, p + 3 - d), e[d]);
  endtask

  // Issues one Start and runs until Done or the cycle bound. cyc counts
  // negedges after the accepting edge. Codes shown during the output window
  // of frames pa and pb are captured per digit into cap_a / cap_b.
  task automatic run_pass(input bit pass, input bit loop0, input int drop_at,
                          input bit noise, input int reset_at,
                          input int pa, input int pb, input int bound,
                          output int done_cyc, output int busy_cnt, output int done_cnt);
    int cyc;
    @(negedge Clk);
    Start = 1'b1;
    Pass  = pass;
    Loop  = loop0;
    cyc = 0;
    done_cyc = -1;
    busy_cnt = 0;
    done_cnt = 0;
    while (done_cyc < 0 && cyc < bound) begin
      @(negedge Clk);
      cyc++;
      Start = 1'b0;
      if (noise && cyc >= 10 && cyc <= 30) begin
        Start = 1'b1;
        Pass  = cyc[0];
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      for (int j = 0; j < 4; j++) begin
        if (!DigitSel[j]) begin
          if (cyc >= TICK * pa + 2 && cyc <= TICK * pa + 9) cap_a[j] = Code;
          if (cyc >= TICK * pb + 2 && cyc <= TICK * pb + 9) cap_b[j] = Code;
        end
      end
      if (cyc == drop_at) Loop = 1'b0;
      if (reset_at >= 0 && cyc == reset_at) nReset = 1'b0;
      if (reset_at >= 0 && cyc == reset_at + 1) begin
        chk("rst_mid_code", Code, 6);
        chk("rst_mid_sel", DigitSel, 4'b1111);
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_done", Done, 0);
        nReset = 1'b1;
      end
    end
    Start = 1'b0;
    Pass  = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    int bc;
    int nd;
    int busy_seen;

    nReset = 1'b0;
    Start  = 1'b1;
    Pass   = 1'b0;
    Loop   = 1'b0;

    // Reset held for three edges with Start asserted.
    repeat (3) @(negedge Clk);
    chk("reset_code", Code, 6);
    chk("reset_sel", DigitSel, 4'b1111);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    nReset = 1'b1;
    Start  = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Busy) busy_seen++;
    end
    chk("no_start_after_reset", busy_seen, 0);

    // Hand-computed frames pin the model's padded-string lookup.
    pin_frame("model_succ_p4", 1'b1, 4, 3, 4, 5, 5);
    pin_frame("model_succ_p7", 1'b1, 7, 5, 0, 3, 3);
    pin_frame("model_succ_p11", 1'b1, 11, 6, 6, 6, 6);
    pin_frame("model_err_p4", 1'b0, 4, 0, 1, 1, 2);
    pin_frame("model_err_p5", 1'b0, 5, 1, 1, 2, 1);
    pin_frame("model_err_p0", 1'b0, 0, 6, 6, 6, 6);

    // SUCCESS pass: 12 frames; Done after edge N+97.
    run_pass(1'b1, 1'b0, -1, 1'b0, -1, 4, 7, 400, dc, bc, nd);
    chk("succ_done_cyc", dc, 98);
    chk("succ_busy_cycles", bc, 97);
    chk("succ_done_pulses", nd, 1);
    for (int j = 0; j < 4; j++) chk("succ_p4_digit", cap_a[j], letter(1'b1, 7 - j));
    chk("succ_p7_d3", cap_b[3], 5);
    chk("succ_p7_d0", cap_b[0], 3);
    run_pass(1'b1, 1'b0, -1, 1'b0, -1, 11, 0, 400, dc, bc, nd);
    for (int j = 0; j < 4; j++) chk("succ_p11_digit", cap_a[j], 6);

    // ERROR pass: 10 frames.
    run_pass(1'b0, 1'b0, -1, 1'b0, -1, 4, 5, 400, dc, bc, nd);
    chk("err_done_cyc", dc, 82);
    chk("err_done_pulses", nd, 1);
    chk("err_p4_d3", cap_a[3], 0);
    chk("err_p4_d2", cap_a[2], 1);
    chk("err_p4_d1", cap_a[1], 1);
    chk("err_p4_d0", cap_a[0], 2);
    chk("err_p5_d3", cap_b[3], 1);
    chk("err_p5_d0", cap_b[0], 1);

    // Loop for two passes, drop Loop during the third.
    run_pass(1'b0, 1'b1, 170, 1'b0, -1, 4, 5, 400, dc, bc, nd);
    chk("loop_done_cyc", dc, 242);
    chk("loop_done_pulses", nd, 1);

    // Start/Pass activity during an ERROR scroll is ignored.
    run_pass(1'b0, 1'b0, -1, 1'b1, -1, 4, 5, 400, dc, bc, nd);
    chk("noise_done_cyc", dc, 82);
    chk("noise_p4_d0", cap_a[0], 2);
    chk("noise_p5_d3", cap_b[3], 1);

    // Reset at p=3: IDLE outputs next cycle and no Done afterwards.
    run_pass(1'b0, 1'b0, -1, 1'b0, 28, 4, 5, 120, dc, bc, nd);
    chk("rst_mid_no_done", nd, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Start  = ($urandom_range(0, 15) == 0);
      Pass   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) Loop = ~Loop;
      nReset = ($urandom_range(0, 299) != 0);
    end
    @(negedge Clk);
    Start  = 1'b0;
    Loop   = 1'b0;
    nReset = 1'b1;
    repeat (300) @(negedge Clk);
    chk("drain_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
